mux4way_arb: RTL and testbench

MUX4WAY_ARB -- requirements
Module: mux4way_arb

---
 rtl/mux4way_arb.sv | 98 +++++++++
 tb/tb_mux4way_arb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4way_arb.sv
// Four-source round-robin merge into a single registered valid/ready stream.
// The index of the source that supplied each word is carried on out_sel.
//
// state | meaning
// EMPTY | output register holds no word; out_valid=0
// FULL  | output register holds a word awaiting the sink; out_valid=1
module mux4way_arb #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [1:0]       ptr;
  logic [3:0]       req_rot;
  logic [1:0]       offset;
  logic [1:0]       grant_idx;
  logic             grant;
  logic             load_ok;
  logic [WIDTH-1:0] word_sel;

  assign load_ok = (state == EMPTY) || out_ready;

  // Rotate requests so bit 0 is the source at ptr; lowest set bit wins.
  assign req_rot = 4'({in_valid, in_valid} >> ptr);

  always_comb begin
    offset = 2'd0;
    casez (req_rot)
      4'b???1: offset = 2'd0;
      4'b??10: offset = 2'd1;
      4'b?100: offset = 2'd2;
      4'b1000: offset = 2'd3;
      default: offset = 2'd0;
    endcase
  end

  assign grant_idx = ptr + offset;
  assign grant     = reset_n && load_ok && (in_valid != 4'b0000);
  assign in_ready  = grant ? (4'b0001 << grant_idx) : 4'b0000;

  always_comb begin
    word_sel = a;
    case (grant_idx)
      2'd0: word_sel = a;
      2'd1: word_sel = b;
      2'd2: word_sel = c;
      2'd3: word_sel = d;
      default: word_sel = a;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (grant) state_nxt = FULL;
      FULL:  if (out_ready && !grant) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Data and pointer only move on a grant; a pure drain leaves them untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out     <= '0;
      out_sel <= 2'd0;
      ptr     <= 2'd0;
    end else if (grant) begin
      out     <= word_sel;
      out_sel <= grant_idx;
      ptr     <= grant_idx + 2'd1;
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: tb/tb_mux4way_arb.sv
// Self-checking bench for mux4way_arb: directed scenarios plus randomized
// traffic compared against a cycle-level round-robin reference model.
module tb_mux4way_arb;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] a, b, c, d;
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [WIDTH-1:0] out;
  logic [1:0]       out_sel;
  logic             out_valid;
  logic             out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int               m_ptr;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_sel;
  logic [WIDTH-1:0] sb_q[$];

  mux4way_arb #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .a(a), .b(b), .c(c), .d(d),
    .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] word_of(int i);
    case (i)
      0: return a;
      1: return b;
      2: return c;
      default: return d;
    endcase
  endfunction

  function automatic int grant_of();
    if (!reset_n) return -1;
    if (m_valid && !out_ready) return -1;
    for (int k = 0; k < 4; k++)
      if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = grant_of();
    if (g < 0) return 4'b0000;
    return 4'b0001 << g;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_sel = 0;
    sb_q.delete();
  endtask

  // Advance one clock edge and update the model; returns at negedge + 1.
  task automatic tick();
    int g;
    logic [WIDTH-1:0] w;
    g = grant_of();
    w = (g >= 0) ? word_of(g) : '0;
    @(posedge clk);
    if (g >= 0) begin
      m_data = w; m_sel = g; m_valid = 1'b1; m_ptr = (g + 1) % 4;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    a = 16'h000A; b = 16'h000B; c = 16'h000C; d = 16'h000D;
    model_reset();
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out !== '0 || out_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_out: got valid=%b out=%h sel=%0d want 0/0000/0", out_valid, out, out_sel);
    end
    @(posedge clk); @(posedge clk); #1;
    n_chk++;
    if (in_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 0000", in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1; in_valid = 4'b0000;
    #1;
  endtask

  task automatic test_round_robin();
    logic [3:0] rr_ready[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (in_ready !== rr_ready[i] || in_ready !== exp_ready()) begin
        n_fail++; $display("FAIL rr_in_ready[%0d]: got %b want %b", i, in_ready, rr_ready[i]);
      end
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || out_sel !== 2'(i % 4) || out !== 16'(16'h000A + i % 4)) begin
        n_fail++;
        $display("FAIL rr_out[%0d]: got valid=%b sel=%0d out=%h want 1/%0d/%h",
                 i, out_valid, out_sel, out, i % 4, 16'h000A + i % 4);
      end
    end
  endtask

  task automatic test_single_source();
    in_valid = 4'b0000; out_ready = 1'b1;
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: got valid=%b want 0", out_valid);
    end
    c = 16'h1234; in_valid = 4'b0100;
    tick();
    in_valid = 4'b0000;
    #1;
    n_chk++;
    if (out !== 16'h1234 || out_sel !== 2'd2 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_out: got out=%h sel=%0d valid=%b want 1234/2/1", out, out_sel, out_valid);
    end
    n_chk++;
    if (dut.ptr !== 2'd3 || m_ptr != 3) begin
      n_fail++; $display("FAIL single_ptr: got %0d want 3", dut.ptr);
    end
  endtask

  task automatic test_backpressure();
    a = 16'h00FF; in_valid = 4'b0001; out_ready = 1'b1;
    tick();
    n_chk++;
    if (out !== 16'h00FF || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_load: got out=%h valid=%b want 00FF/1", out, out_valid);
    end
    a = 16'h0AAA; in_valid = 4'b1111; out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (in_ready !== 4'b0000) begin
        n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", i, in_ready);
      end
      tick();
      n_chk++;
      if (out !== 16'h00FF || out_valid !== 1'b1 || out_sel !== 2'd0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got out=%h valid=%b sel=%0d want 00FF/1/0", i, out, out_valid, out_sel);
      end
    end
    out_ready = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 4'b0010 || in_ready !== exp_ready()) begin
      n_fail++; $display("FAIL bp_release_ready: got %b want 0010", in_ready);
    end
    tick();
    n_chk++;
    if (out_sel !== 2'd1 || out !== b || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_out: got sel=%0d out=%h want 1/%h", out_sel, out, b);
    end
  endtask

  task automatic test_drain_load();
    b = 16'hBEEF; in_valid = 4'b0010; out_ready = 1'b1;
    tick();
    n_chk++;
    if (out !== 16'hBEEF || out_sel !== 2'd1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_load: got out=%h sel=%0d valid=%b want BEEF/1/1", out, out_sel, out_valid);
    end
  endtask

  task automatic test_wrap();
    in_valid = 4'b0100; out_ready = 1'b1;
    tick();
    in_valid = 4'b1001;
    #1;
    n_chk++;
    if (in_ready !== 4'b1000) begin
      n_fail++; $display("FAIL wrap_ready3: got %b want 1000", in_ready);
    end
    tick();
    n_chk++;
    if (out_sel !== 2'd3 || out !== d || dut.ptr !== 2'd0) begin
      n_fail++; $display("FAIL wrap_out3: got sel=%0d ptr=%0d want 3/0", out_sel, dut.ptr);
    end
    n_chk++;
    if (in_ready !== 4'b0001) begin
      n_fail++; $display("FAIL wrap_ready0: got %b want 0001", in_ready);
    end
    tick();
    n_chk++;
    if (out_sel !== 2'd0 || out !== a) begin
      n_fail++; $display("FAIL wrap_out0: got sel=%0d out=%h want 0/%h", out_sel, out, a);
    end
  endtask

  task automatic test_random();
    int starve;
    in_valid = 4'b0000; out_ready = 1'b1;
    tick();
    sb_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
      in_valid = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_chk++;
      if (in_ready !== exp_ready()) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", cyc, in_ready, exp_ready());
      end
      n_chk++;
      if (out_valid !== m_valid || (m_valid && (out !== m_data || out_sel !== 2'(m_sel)))) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: got v=%b out=%h sel=%0d want v=%b out=%h sel=%0d",
                 cyc, out_valid, out, out_sel, m_valid, m_data, m_sel);
      end
      if (out_valid && out_ready) begin
        n_chk++;
        if (sb_q.size() == 0 || out !== sb_q[0]) begin
          n_fail++; $display("FAIL rand_order[%0d]: got %h, expected queue head missing or differs", cyc, out);
        end
        if (sb_q.size() != 0) void'(sb_q.pop_front());
      end
      for (int i = 0; i < 4; i++)
        if (in_valid[i] && in_ready[i]) sb_q.push_back(word_of(i));
      tick();
    end
    // Starvation bound: source 1 always requesting is served within 4 grants.
    in_valid = 4'b1111; out_ready = 1'b1; starve = 0;
    #1;
    while (in_ready[1] !== 1'b1 && starve < 6) begin
      tick(); starve++;
    end
    n_chk++;
    if (starve > 3) begin
      n_fail++; $display("FAIL rand_starve: got %0d grants before source1, want <=3", starve);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    in_valid = 4'b0100; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 4'b1111;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out !== '0 || out_sel !== 2'd0 || in_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_clear: got v=%b out=%h sel=%0d rdy=%b want 0/0000/0/0000",
               out_valid, out, out_sel, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
    #1;
    n_chk++;
    if (in_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rstmid_ready: got %b want 0001", in_ready);
    end
    tick();
    n_chk++;
    if (out_sel !== 2'd0 || out !== a || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_first: got sel=%0d v=%b want 0/1", out_sel, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_source();
    test_backpressure();
    test_drain_load();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
